// File: rtl/inic_ram_seq_if.sv
// Bus bundle between a start/abort controller (master) and the RAM init sequencer (slave).
interface inic_ram_seq_if #(
    parameter int unsigned RAM_AW = 32,
    parameter int unsigned ROM_AW = 17
);
    logic              do_it_inic_ram;
    logic              abort;
    logic              rom_to_ram;
    logic [ROM_AW-1:0] dir_rom;
    logic              rom_enable;
    logic [RAM_AW-1:0] dir_ram;
    logic              w_ram_enable;
    logic              r_ram_enable;
    logic              busy;
    logic              done;

    modport master (
        output do_it_inic_ram,
        output abort,
        input  rom_to_ram,
        input  dir_rom,
        input  rom_enable,
        input  dir_ram,
        input  w_ram_enable,
        input  r_ram_enable,
        input  busy,
        input  done
    );

    modport slave (
        input  do_it_inic_ram,
        input  abort,
        output rom_to_ram,
        output dir_rom,
        output rom_enable,
        output dir_ram,
        output w_ram_enable,
        output r_ram_enable,
        output busy,
        output done
    );
endinterface

// File: rtl/inic_ram_seq.sv
// RAM initialisation sequencer: walks RAM positions 0..N_REG-1, copying ROM entry 0 into the
// first N_ZERO positions and ROM entries 1.. into the rest. Optional one-cycle ROM latency.
module inic_ram_seq #(
    parameter int unsigned N_REG  = 32,
    parameter int unsigned N_ZERO = 16,
    parameter int unsigned ONEHOT = 1,
    parameter int unsigned RD_LAT = 0
) (
    input logic           clk,
    input logic           reset,
    inic_ram_seq_if.slave bus
);
    localparam int unsigned ROM_D  = N_REG - N_ZERO + 1;
    localparam int unsigned RAM_AW = (ONEHOT != 0) ? N_REG : $clog2(N_REG);
    localparam int unsigned ROM_AW = (ONEHOT != 0) ? ROM_D : $clog2(ROM_D);
    localparam int unsigned IW     = $clog2(N_REG + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic          r_pipe_vld;
    logic [IW-1:0] r_pipe_idx;
    logic          w_last;
    logic          w_rom_act;
    logic          w_ram_act;
    logic [IW-1:0] w_rom_idx;
    logic [IW-1:0] w_ram_idx;

    assign w_last = (r_idx == IW'(N_REG - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort only matters while a run is in flight
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (bus.do_it_inic_ram) w_state_nxt = StRun;
            StRun: begin
                if (bus.abort) begin
                    w_state_nxt = StIdle;
                end else if (w_last) begin
                    w_state_nxt = (RD_LAT != 0) ? StDrain : StDone;
                end
            end
            StDrain: w_state_nxt = bus.abort ? StIdle : StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Position counter: counts through RUN, held at zero everywhere else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
        end else if ((r_state == StRun) && !bus.abort) begin
            r_idx <= r_idx + IW'(1);
        end else begin
            r_idx <= '0;
        end
    end

    // Write stage that trails the ROM address by one cycle when ROM data is registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipe_vld <= 1'b0;
            r_pipe_idx <= '0;
        end else begin
            r_pipe_vld <= (r_state == StRun) && !bus.abort;
            r_pipe_idx <= r_idx;
        end
    end

    // Output decode: ROM/RAM addresses are zero whenever their side is idle
    always_comb begin
        w_rom_act = (r_state == StRun);
        w_ram_act = (RD_LAT != 0) ? r_pipe_vld : (r_state == StRun);
        w_ram_idx = (RD_LAT != 0) ? r_pipe_idx : r_idx;
        // Signed compare keeps N_ZERO == 0 from becoming a constant unsigned test
        if (int'(r_idx) < int'(N_ZERO)) begin
            w_rom_idx = '0;
        end else begin
            w_rom_idx = r_idx - IW'(N_ZERO) + IW'(1);
        end

        bus.rom_enable   = w_rom_act;
        bus.w_ram_enable = w_ram_act;
        bus.rom_to_ram   = w_rom_act | w_ram_act;
        bus.r_ram_enable = 1'b0;
        bus.busy         = (r_state == StRun) || (r_state == StDrain);
        bus.done         = (r_state == StDone);
        bus.dir_rom      = '0;
        bus.dir_ram      = '0;
        if (w_rom_act) begin
            bus.dir_rom = (ONEHOT != 0) ? (ROM_AW'(1) << w_rom_idx) : ROM_AW'(w_rom_idx);
        end
        if (w_ram_act) begin
            bus.dir_ram = (ONEHOT != 0) ? (RAM_AW'(1) << w_ram_idx) : RAM_AW'(w_ram_idx);
        end
    end
endmodule

// File: tb/tb_inic_ram_seq.sv
// Scoreboard bench for inic_ram_seq: three configurations, expected writes queued at start,
// per-instance monitors pop and compare on every RAM write strobe.
module tb_inic_ram_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic do_a = 1'b0, ab_a = 1'b0;
    logic do_b = 1'b0, ab_b = 1'b0;
    logic do_c = 1'b0, ab_c = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int done_a = 0, done_b = 0, done_c = 0;
    bit rom0_c = 1'b0;
    logic [4:0] prev_rom_b = '0;
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    logic [63:0] q_c[$];
    logic [63:0] e_a, e_b, e_c;

    always #5 clk = ~clk;

    inic_ram_seq_if #(.RAM_AW(32), .ROM_AW(17)) bus_a ();
    inic_ram_seq_if #(.RAM_AW(5),  .ROM_AW(5))  bus_b ();
    inic_ram_seq_if #(.RAM_AW(8),  .ROM_AW(9))  bus_c ();

    assign bus_a.do_it_inic_ram = do_a;
    assign bus_a.abort          = ab_a;
    assign bus_b.do_it_inic_ram = do_b;
    assign bus_b.abort          = ab_b;
    assign bus_c.do_it_inic_ram = do_c;
    assign bus_c.abort          = ab_c;

    inic_ram_seq #(.N_REG(32), .N_ZERO(16), .ONEHOT(1), .RD_LAT(0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    inic_ram_seq #(.N_REG(32), .N_ZERO(16), .ONEHOT(0), .RD_LAT(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );
    inic_ram_seq #(.N_REG(8), .N_ZERO(0), .ONEHOT(1), .RD_LAT(0)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int rom_idx(input int i, input int nz);
        return (i < nz) ? 0 : i - nz + 1;
    endfunction

    task automatic push_a(input int i);
        logic [16:0] r;
        logic [31:0] m;
        r = 17'd1 << rom_idx(i, 16);
        m = 32'd1 << i;
        q_a.push_back({13'b0, 2'b11, r, m});
    endtask

    task automatic push_b(input int i);
        q_b.push_back({53'b0, 1'b1, 5'(rom_idx(i, 16)), 5'(i)});
    endtask

    task automatic push_c(input int i);
        logic [8:0] r;
        logic [7:0] m;
        r = 9'd1 << (i + 1);
        m = 8'd1 << i;
        q_c.push_back({45'b0, 2'b11, r, m});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs_a();
        return {9'b0, bus_a.busy, bus_a.done, bus_a.r_ram_enable, bus_a.w_ram_enable,
                bus_a.rom_enable, bus_a.rom_to_ram, bus_a.dir_rom, bus_a.dir_ram};
    endfunction

    // Monitor A
    always @(negedge clk) begin
        if (bus_a.done === 1'b1) done_a++;
        if (bus_a.w_ram_enable === 1'b1) begin
            if (q_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL a_extra_write: got dir_ram=%h expected no write", bus_a.dir_ram);
            end else begin
                e_a = q_a.pop_front();
                check("a_write", {13'b0, bus_a.rom_to_ram, bus_a.rom_enable, bus_a.dir_rom,
                                  bus_a.dir_ram}, e_a);
            end
        end
    end

    // Monitor B: ROM address is compared one cycle late, matching the write it feeds
    always @(negedge clk) begin
        if (bus_b.done === 1'b1) done_b++;
        if (bus_b.w_ram_enable === 1'b1) begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b_extra_write: got dir_ram=%h expected no write", bus_b.dir_ram);
            end else begin
                e_b = q_b.pop_front();
                check("b_write", {53'b0, bus_b.rom_to_ram, prev_rom_b, bus_b.dir_ram}, e_b);
            end
        end
        prev_rom_b <= bus_b.dir_rom;
    end

    // Monitor C
    always @(negedge clk) begin
        if (bus_c.done === 1'b1) done_c++;
        if ((bus_c.rom_enable === 1'b1) && (bus_c.dir_rom[0] === 1'b1)) rom0_c = 1'b1;
        if (bus_c.w_ram_enable === 1'b1) begin
            if (q_c.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL c_extra_write: got dir_ram=%h expected no write", bus_c.dir_ram);
            end else begin
                e_c = q_c.pop_front();
                check("c_write", {45'b0, bus_c.rom_to_ram, bus_c.rom_enable, bus_c.dir_rom,
                                  bus_c.dir_ram}, e_c);
            end
        end
    end

    initial begin
        step();
        step();
        check("reset_a_outputs", outs_a(), 64'd0);
        check("reset_b_busy_done", {62'b0, bus_b.busy, bus_b.done}, 64'd0);
        reset = 1'b0;
        step();

        // Defaults, single-cycle start pulse
        for (int i = 0; i < 32; i++) push_a(i);
        do_a = 1'b1;
        step();
        do_a = 1'b0;
        check("a_idx0", {15'b0, bus_a.dir_rom, bus_a.dir_ram}, {15'b0, 17'h00001, 32'h00000001});
        check("a_busy_run", {63'b0, bus_a.busy}, 64'd1);
        repeat (17) step();
        check("a_idx17", {15'b0, bus_a.dir_rom, bus_a.dir_ram}, {15'b0, 17'h00004, 32'h00020000});
        repeat (14) step();
        check("a_idx31", {15'b0, bus_a.dir_rom, bus_a.dir_ram}, {15'b0, 17'h10000, 32'h80000000});
        step();
        check("a_done_pulse", {62'b0, bus_a.busy, bus_a.done}, 64'd1);
        step();
        check("a_done_clear", {62'b0, bus_a.busy, bus_a.done}, 64'd0);
        check("a_queue_drained", 64'(q_a.size()), 64'd0);
        check("a_done_count", 64'(done_a), 64'd1);

        // Binary addresses, registered ROM
        for (int i = 0; i < 32; i++) push_b(i);
        do_b = 1'b1;
        step();
        do_b = 1'b0;
        repeat (20) step();
        check("b_rom_c20", {58'b0, bus_b.rom_enable, bus_b.dir_rom}, {58'b0, 1'b1, 5'd5});
        check("b_wr_c20", {58'b0, bus_b.w_ram_enable, bus_b.dir_ram}, {58'b0, 1'b1, 5'd19});
        step();
        check("b_wr_c21", {58'b0, bus_b.w_ram_enable, bus_b.dir_ram}, {58'b0, 1'b1, 5'd20});
        repeat (11) step();
        check("b_drain", {51'b0, bus_b.busy, bus_b.rom_enable, bus_b.dir_rom,
                          bus_b.w_ram_enable, bus_b.dir_ram},
              {51'b0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd31});
        step();
        check("b_done_pulse", {62'b0, bus_b.busy, bus_b.done}, 64'd1);
        step();
        check("b_done_clear", {62'b0, bus_b.busy, bus_b.done}, 64'd0);
        check("b_queue_drained", 64'(q_b.size()), 64'd0);
        check("b_done_count", 64'(done_b), 64'd1);

        // No leading zero block: ROM 1..8 into RAM 0..7
        for (int i = 0; i < 8; i++) push_c(i);
        do_c = 1'b1;
        step();
        do_c = 1'b0;
        check("c_idx0", {47'b0, bus_c.dir_rom, bus_c.dir_ram}, {47'b0, 9'h002, 8'h01});
        repeat (8) step();
        check("c_done_pulse", {62'b0, bus_c.busy, bus_c.done}, 64'd1);
        step();
        check("c_queue_drained", 64'(q_c.size()), 64'd0);
        check("c_rom0_never_read", {63'b0, rom0_c}, 64'd0);
        check("c_done_count", 64'(done_c), 64'd1);

        // Abort at idx 10, then restart with start and abort both high in IDLE
        for (int i = 0; i <= 10; i++) push_a(i);
        do_a = 1'b1;
        step();
        do_a = 1'b0;
        repeat (10) step();
        ab_a = 1'b1;
        step();
        ab_a = 1'b0;
        check("abort_idle", {60'b0, bus_a.busy, bus_a.w_ram_enable, bus_a.done, bus_a.rom_enable},
              64'd0);
        repeat (4) step();
        check("abort_no_done", 64'(done_a), 64'd1);
        check("abort_queue_drained", 64'(q_a.size()), 64'd0);
        for (int i = 0; i < 32; i++) push_a(i);
        do_a = 1'b1;
        ab_a = 1'b1;
        step();
        do_a = 1'b0;
        ab_a = 1'b0;
        check("restart_idx0", {31'b0, bus_a.busy, bus_a.dir_ram}, {31'b0, 1'b1, 32'h00000001});
        repeat (32) step();
        check("restart_done", {63'b0, bus_a.done}, 64'd1);
        step();
        check("restart_queue_drained", 64'(q_a.size()), 64'd0);
        check("restart_done_count", 64'(done_a), 64'd2);

        // Asynchronous reset mid-run
        for (int i = 0; i < 5; i++) push_a(i);
        do_a = 1'b1;
        step();
        do_a = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        #1;
        check("reset_async_outputs", outs_a(), 64'd0);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check("reset_stays_idle", {62'b0, bus_a.busy, bus_a.w_ram_enable}, 64'd0);
        check("reset_no_done", 64'(done_a), 64'd2);
        check("reset_queue_drained", 64'(q_a.size()), 64'd0);

        // Held request: back-to-back runs with one IDLE cycle between
        for (int r = 0; r < 2; r++) for (int i = 0; i < 32; i++) push_a(i);
        do_a = 1'b1;
        step();
        repeat (32) step();
        check("held_done1", {62'b0, bus_a.busy, bus_a.done}, 64'd1);
        step();
        check("held_idle_gap", {61'b0, bus_a.busy, bus_a.done, bus_a.w_ram_enable}, 64'd0);
        step();
        check("held_run2_idx0", {31'b0, bus_a.busy, bus_a.dir_ram}, {31'b0, 1'b1, 32'h00000001});
        do_a = 1'b0;
        repeat (32) step();
        check("held_done2", {62'b0, bus_a.busy, bus_a.done}, 64'd1);
        step();
        check("held_queue_drained", 64'(q_a.size()), 64'd0);
        check("held_done_count", 64'(done_a), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
